// File: rtl/fifo_burst_ctrl_if.sv
// Command, FIFO and result signals of the burst controller, bundled as one interface.
// No logic, so no latency of its own.
// Backpressure is carried by cmd_ready and by the FIFO data_count/ack signals.
interface fifo_burst_ctrl_if #(
    parameter int DW = 32
);
    // command side
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rd;
    logic [3:0]    cmd_len;
    logic [DW-1:0] cmd_base;
    // FIFO side
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [3:0]    data_count;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;
    // result side
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          err;
    logic [3:0]    xfer_count;

    // controller view
    modport master (
        input  cmd_valid, cmd_rd, cmd_len, cmd_base,
        input  dout, data_count, wr_ack, wr_err, rd_ack, rd_err,
        output cmd_ready, wr_en, rd_en, din,
        output rd_valid, rd_data, done, err, xfer_count
    );

    // environment view (command source plus FIFO)
    modport slave (
        output cmd_valid, cmd_rd, cmd_len, cmd_base,
        output dout, data_count, wr_ack, wr_err, rd_ack, rd_err,
        input  cmd_ready, wr_en, rd_en, din,
        input  rd_valid, rd_data, done, err, xfer_count
    );
endinterface

// File: rtl/fifo_burst_ctrl.sv
// Turns one write/read burst command into a legal wr_en/rd_en sequence for an 8-deep FIFO.
// Latency: accept -> first enable 1 cycle; last enable -> done 2 cycles.
// Enables are gated on data_count so full/empty are never hit; STALL_MAX idle cycles abort.
module fifo_burst_ctrl #(
    parameter int DW        = 32,
    parameter int DEPTH     = 8,
    parameter int STALL_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    fifo_burst_ctrl_if.master bus
);

    localparam int         SW      = $clog2(STALL_MAX + 1);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [3:0]    len_q;
    logic [3:0]    idx_q;
    logic [3:0]    xfer_q;
    logic [SW-1:0] stall_q;
    logic [DW-1:0] base_q;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          done_q;
    logic          err_q;

    logic          fifo_err;
    logic          any_ack;
    logic          space_ok;
    logic          data_ok;
    logic          wr_fire;
    logic          rd_fire;
    logic          fire;
    logic          accept;
    logic [3:0]    len_d;
    logic [3:0]    xfer_d;

    // An error handshake blocks the enable in the very cycle it is seen;
    // an out-of-range data_count reads as both full and non-empty.
    assign fifo_err = bus.wr_err | bus.rd_err;
    assign any_ack  = bus.wr_ack | bus.rd_ack;
    assign space_ok = bus.data_count < DEPTH_C;
    assign data_ok  = bus.data_count != 4'd0;
    assign wr_fire  = !reset && (state_q == S_WR) && space_ok && !fifo_err;
    assign rd_fire  = !reset && (state_q == S_RD) && data_ok && !fifo_err;
    assign fire     = wr_fire | rd_fire;

    assign bus.cmd_ready = !reset && (state_q == S_IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign len_d         = (bus.cmd_len > DEPTH_C) ? DEPTH_C : bus.cmd_len;
    // Acks keep counting in every state; a new command restarts the count.
    assign xfer_d        = accept ? 4'd0 : xfer_q + {3'd0, any_ack};

    assign bus.wr_en      = wr_fire;
    assign bus.rd_en      = rd_fire;
    assign bus.din        = base_q + DW'(idx_q);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.xfer_count = xfer_q;

    // Burst sequencer plus registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            xfer_q     <= '0;
            stall_q    <= '0;
            base_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= bus.rd_ack;
            if (bus.rd_ack) begin
                rd_data_q <= bus.dout;
            end
            xfer_q <= xfer_d;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        len_q   <= len_d;
                        base_q  <= bus.cmd_base;
                        idx_q   <= '0;
                        stall_q <= '0;
                        err_q   <= 1'b0;
                        if (len_d == 4'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= bus.cmd_rd ? S_RD : S_WR;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (fifo_err) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (fire) begin
                        idx_q   <= idx_q + 4'd1;
                        stall_q <= '0;
                        if (idx_q + 4'd1 == len_q) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (stall_q == SW'(STALL_MAX - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_err) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (xfer_d == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (fifo_err) begin
                        err_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Bench for fifo_burst_ctrl: behavioural 8-deep FIFO plus outcome model per command.
// Table vectors, hand sequences (read-back, reset mid-burst, wr_err) and random commands.
// Outputs are sampled on the falling edge; inputs change on the falling edge or #1 after rise.
module tb_fifo_burst_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_burst_ctrl_if #(.DW(32)) bus ();

    fifo_burst_ctrl #(.DW(32), .DEPTH(8), .STALL_MAX(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural FIFO ----------------
    logic [31:0] fq[$];
    logic        pf_req      = 1'b0;
    int          pf_n        = 0;
    logic [31:0] pf_data[8];
    logic        inj_wr_err  = 1'b0;
    logic        dc_ovr_en   = 1'b0;
    logic [31:0] exp_rd[8];

    always @(posedge clk) begin
        logic        wa, we, ra, re;
        logic [31:0] d;
        wa = 1'b0; we = 1'b0; ra = 1'b0; re = 1'b0;
        d  = bus.dout;
        if (pf_req) begin
            fq.delete();
            for (int i = 0; i < pf_n; i++) fq.push_back(pf_data[i]);
        end
        if (bus.wr_en) begin
            if (inj_wr_err || fq.size() >= 8) we = 1'b1;
            else begin
                fq.push_back(bus.din);
                wa = 1'b1;
            end
        end
        if (bus.rd_en) begin
            if (fq.size() == 0) re = 1'b1;
            else begin
                d  = fq.pop_front();
                ra = 1'b1;
            end
        end
        bus.wr_ack     <= wa;
        bus.wr_err     <= we;
        bus.rd_ack     <= ra;
        bus.rd_err     <= re;
        bus.dout       <= d;
        bus.data_count <= dc_ovr_en ? 4'd9 : 4'(fq.size());
    end

    // ---------------- command outcome model ----------------
    typedef struct {
        bit          rd;
        logic [3:0]  len;
        logic [31:0] base;
        int          pf;        // words preloaded into the FIFO, -1 = keep contents
        bit          ovr;       // force data_count to the illegal value 9
        int          n;         // enables expected
        bit          err;
        int          xfer;
        int          done_cyc;  // cycles after the accept edge
    } vec_t;

    // Words moved = min(clamped length, words/space available); shortfall means a
    // 16-cycle stall abort. Done lands 2 cycles after the last enable.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   l     = (int'(v.len) > 8) ? 8 : int'(v.len);
        int   avail = v.rd ? v.pf : 8 - v.pf;
        r.n        = (l < avail) ? l : avail;
        r.err      = r.n < l;
        r.xfer     = r.n;
        r.done_cyc = (l == 0) ? 1 : (r.err ? r.n + 17 : r.n + 2);
        return r;
    endfunction

    task automatic run_cmd(input vec_t v, input string tag);
        int   cyc = 1, nen = 0, wrong_en = 0, first_en = -1, last_en = -1, nrv = 0, done_cyc = -1;
        logic got_err  = 1'b0;
        logic [3:0] got_xfer = 4'd0;
        if (v.pf >= 0) begin
            @(negedge clk);
            dc_ovr_en = v.ovr;
            pf_n      = v.pf;
            pf_req    = 1'b1;
            @(negedge clk);
            pf_req = 1'b0;
            for (int i = 0; i < 8; i++) exp_rd[i] = pf_data[i];
        end else begin
            @(negedge clk);
        end
        check({tag, "/cmd_ready_idle"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = v.rd;
        bus.cmd_len   = v.len;
        bus.cmd_base  = v.base;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 4'($urandom_range(0, 15));
        check({tag, "/err_cleared"}, bus.err, 0);
        while (cyc <= 100) begin
            if (bus.wr_en || bus.rd_en) begin
                if ((bus.wr_en && v.rd) || (bus.rd_en && !v.rd)) wrong_en++;
                else begin
                    if (bus.wr_en) check({tag, "/din"}, bus.din, v.base + 32'(nen));
                    nen++;
                    if (first_en < 0) first_en = cyc;
                    last_en = cyc;
                end
            end
            if (bus.rd_valid) begin
                if (nrv < 8) check({tag, "/rd_data"}, bus.rd_data, exp_rd[nrv]);
                nrv++;
            end
            if (bus.done) begin
                done_cyc = cyc;
                got_err  = bus.err;
                got_xfer = bus.xfer_count;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: no done within 100 cycles, expected at cycle %0d", tag, v.done_cyc);
        end
        check({tag, "/enables"}, nen, v.n);
        check({tag, "/wrong_dir_en"}, wrong_en, 0);
        if (v.n > 0) begin
            check({tag, "/first_en_cyc"}, first_en, 1);
            check({tag, "/last_en_cyc"}, last_en, v.n);
        end
        check({tag, "/done_cyc"}, done_cyc, v.done_cyc);
        check({tag, "/err"}, got_err, v.err);
        check({tag, "/xfer_count"}, got_xfer, v.xfer);
        check({tag, "/rd_valid_cnt"}, nrv, v.rd ? v.xfer : 0);
        @(negedge clk);
        check({tag, "/done_one_pulse"}, bus.done, 0);
        check({tag, "/cmd_ready_after"}, bus.cmd_ready, 1);
        dc_ovr_en = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rd    = 1'b0;
        bus.cmd_len   = 4'd0;
        bus.cmd_base  = 32'd0;
        for (int i = 0; i < 8; i++) pf_data[i] = 32'hA0 + 32'(i);

        //           rd len  base           pf ovr  n err xfer done
        tbl[0]  = '{1'b0, 4'd8,  32'h0,        6, 1'b0, 2, 1'b1, 2, 19};
        tbl[1]  = '{1'b1, 4'd2,  32'h0,        0, 1'b0, 0, 1'b1, 0, 17};
        tbl[2]  = '{1'b0, 4'd3,  32'h100,      0, 1'b0, 3, 1'b0, 3, 5};
        tbl[3]  = '{1'b0, 4'd0,  32'h55,       0, 1'b0, 0, 1'b0, 0, 1};
        tbl[4]  = '{1'b0, 4'd12, 32'hFFFFFFFE, 0, 1'b0, 8, 1'b0, 8, 10};
        tbl[5]  = '{1'b1, 4'd5,  32'h0,        8, 1'b0, 5, 1'b0, 5, 7};
        tbl[6]  = '{1'b1, 4'd15, 32'h0,        8, 1'b0, 8, 1'b0, 8, 10};
        tbl[7]  = '{1'b0, 4'd4,  32'h20,       5, 1'b0, 3, 1'b1, 3, 20};
        tbl[8]  = '{1'b1, 4'd0,  32'h0,        3, 1'b0, 0, 1'b0, 0, 1};
        tbl[9]  = '{1'b0, 4'd2,  32'h0,        0, 1'b1, 0, 1'b1, 0, 17};
        tbl[10] = '{1'b1, 4'd1,  32'h0,        2, 1'b1, 1, 1'b0, 1, 3};

        // reset state
        repeat (3) @(negedge clk);
        check("rst/cmd_ready", bus.cmd_ready, 0);
        check("rst/wr_en", bus.wr_en, 0);
        check("rst/rd_en", bus.rd_en, 0);
        check("rst/done", bus.done, 0);
        check("rst/err", bus.err, 0);
        check("rst/xfer_count", bus.xfer_count, 0);
        check("rst/rd_valid", bus.rd_valid, 0);
        check("rst/rd_data", bus.rd_data, 0);
        reset = 1'b0;

        // write three words, then read them back through the same FIFO
        run_cmd('{1'b0, 4'd3, 32'h10, 0, 1'b0, 3, 1'b0, 3, 5}, "wr3");
        exp_rd[0] = 32'h10;
        exp_rd[1] = 32'h11;
        exp_rd[2] = 32'h12;
        run_cmd('{1'b1, 4'd3, 32'h0, -1, 1'b0, 3, 1'b0, 3, 5}, "rd3");
        @(negedge clk);
        check("rd3/data_count_end", bus.data_count, 0);

        // table vectors
        for (int i = 0; i < 11; i++) run_cmd(tbl[i], $sformatf("tbl%0d", i));

        // wr_err from the FIFO aborts the burst with no further enables
        inj_wr_err = 1'b1;
        run_cmd('{1'b0, 4'd3, 32'h40, 0, 1'b0, 1, 1'b1, 0, 3}, "wrerr");
        inj_wr_err = 1'b0;

        // reset after the second write of a 5-word burst
        @(negedge clk);
        pf_n   = 0;
        pf_req = 1'b1;
        @(negedge clk);
        pf_req        = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = 1'b0;
        bus.cmd_len   = 4'd5;
        bus.cmd_base  = 32'h70;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("mrst/wr_en_1", bus.wr_en, 1);
        @(negedge clk);
        check("mrst/wr_en_2", bus.wr_en, 1);
        check("mrst/din_2", bus.din, 32'h71);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mrst/wr_en_in_reset", bus.wr_en, 0);
        check("mrst/cmd_ready_in_reset", bus.cmd_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst/cmd_ready_after", bus.cmd_ready, 1);
        check("mrst/xfer_count", bus.xfer_count, 0);
        for (int i = 0; i < 4; i++) begin
            check("mrst/no_done", bus.done, 0);
            check("mrst/no_wr_en", bus.wr_en, 0);
            @(negedge clk);
        end
        check("mrst/fifo_kept", bus.data_count, 2);

        // random commands against the outcome model
        for (int k = 0; k < 40; k++) begin
            v.rd   = 1'($urandom_range(0, 1));
            v.len  = 4'($urandom_range(0, 15));
            v.base = $urandom;
            v.pf   = int'($urandom_range(0, 8));
            v.ovr  = 1'b0;
            for (int i = 0; i < 8; i++) pf_data[i] = $urandom;
            v = model(v);
            run_cmd(v, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
